// File: rtl/register_issue_controller.sv
// Issue scoreboard plus two-unit round-robin write-back arbiter in front of global_register.
// Optional: define ISSUE_STALL_COUNTER_EN to add the saturating stall_cycles_output counter.
module register_issue_controller #(
  parameter int NUM_REGS = 32,
  parameter int DESC_W   = 5,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid_input,
  output logic              issue_ready_output,
  input  logic [DESC_W-1:0] issue_src0_input,
  input  logic [DESC_W-1:0] issue_src1_input,
  input  logic [DESC_W-1:0] issue_dst_input,
  input  logic              issue_dst_valid_input,
  input  logic              wb0_valid_input,
  input  logic              wb1_valid_input,
  input  logic [DESC_W-1:0] wb0_register_input,
  input  logic [DESC_W-1:0] wb1_register_input,
  input  logic [DATA_W-1:0] wb0_result_input,
  input  logic [DATA_W-1:0] wb1_result_input,
  output logic              wb0_ready_output,
  output logic              wb1_ready_output,
  output logic [DESC_W-1:0] register_operand0_output,
  output logic [DESC_W-1:0] register_operand1_output,
  output logic              write_reserve_output,
  output logic              issue_fire_output,
  output logic              write_back_output,
  output logic [DESC_W-1:0] write_back_register_output,
  output logic [DATA_W-1:0] result_output,
  output logic [NUM_REGS-1:0] busy_mask_output,
  output logic              wb_error_output
`ifdef ISSUE_STALL_COUNTER_EN
  ,
  output logic [15:0]       stall_cycles_output
`endif
);

  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_next;
  logic                hazard;
  logic                issue_accept;
  logic                reserve_now;
  logic                rr_ptr;
  logic                grant0;
  logic                grant1;
  logic                any_grant;
  logic [DESC_W-1:0]   grant_reg;
  logic [DATA_W-1:0]   grant_result;
  logic                grant_unreserved;

  // Hazard uses only the registered mask: a register retiring this cycle still stalls.
  always_comb begin
    hazard = busy[issue_src0_input] | busy[issue_src1_input] |
             (issue_dst_valid_input & busy[issue_dst_input]);
  end

  assign issue_ready_output = ~hazard;
  assign issue_accept       = issue_valid_input & ~hazard;
  assign reserve_now        = issue_accept & issue_dst_valid_input & (issue_dst_input != '0);

  // rr_ptr = 0 prefers wb0; grants are suppressed while reset is held.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (rst) begin
      if (wb0_valid_input && wb1_valid_input) begin
        grant0 = ~rr_ptr;
        grant1 = rr_ptr;
      end else begin
        grant0 = wb0_valid_input;
        grant1 = wb1_valid_input;
      end
    end
  end

  assign wb0_ready_output = grant0;
  assign wb1_ready_output = grant1;
  assign any_grant        = grant0 | grant1;
  assign grant_reg        = grant1 ? wb1_register_input : wb0_register_input;
  assign grant_result     = grant1 ? wb1_result_input   : wb0_result_input;
  assign grant_unreserved = any_grant & (grant_reg != '0) & ~busy[grant_reg];

  // Clear is applied before set so an illegal same-edge set/clear leaves the bit reserved.
  always_comb begin
    busy_next = busy;
    if (any_grant && (grant_reg != '0)) begin
      busy_next[grant_reg] = 1'b0;
    end
    if (reserve_now) begin
      busy_next[issue_dst_input] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy            <= '0;
      wb_error_output <= 1'b0;
    end else begin
      busy <= busy_next;
      if (grant_unreserved) begin
        wb_error_output <= 1'b1;
      end
    end
  end

  assign busy_mask_output = busy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      register_operand0_output <= '0;
      register_operand1_output <= '0;
      issue_fire_output        <= 1'b0;
      write_reserve_output     <= 1'b0;
    end else begin
      issue_fire_output    <= issue_accept;
      write_reserve_output <= reserve_now;
      if (issue_accept) begin
        register_operand0_output <= issue_src0_input;
        register_operand1_output <= issue_src1_input;
      end
    end
  end

  // Whichever unit wins, the pointer hands preference to the other one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr                     <= 1'b0;
      write_back_output          <= 1'b0;
      write_back_register_output <= '0;
      result_output              <= '0;
    end else begin
      write_back_output <= any_grant;
      if (any_grant) begin
        rr_ptr                     <= grant0;
        write_back_register_output <= grant_reg;
        result_output              <= grant_result;
      end
    end
  end

`ifdef ISSUE_STALL_COUNTER_EN
  logic [15:0] stall_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_count <= '0;
    end else if (issue_valid_input && hazard && (stall_count != 16'hFFFF)) begin
      stall_count <= stall_count + 16'd1;
    end
  end

  assign stall_cycles_output = stall_count;
`endif

  a_single_grant : assert property (@(posedge clk) disable iff (!rst) !(grant0 && grant1));
  a_zero_free    : assert property (@(posedge clk) disable iff (!rst) !busy[0]);

endmodule
